// File: rtl/mul8u_share_arb_if.sv
// Request/response channel bundle for the shared-multiplier arbiter.
// Request side: per-requester valid/ready with 8-bit operands packed 8*i.
// Response side: single valid/ready channel carrying the requester ID and product.
//
// Signals:
//   req_valid [NREQ]   requester -> arbiter, request pending
//   req_ready [NREQ]   arbiter -> requester, grant (one-hot or zero)
//   req_a/req_b        operand A/B, requester i on bits [8i+7:8i]
//   rsp_valid          arbiter -> consumer, response present
//   rsp_ready          consumer -> arbiter, response accepted
//   rsp_id             index of the requester that issued the operation
//   rsp_data           16-bit product
interface mul8u_share_arb_if #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [8*NREQ-1:0] req_a;
  logic [8*NREQ-1:0] req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [15:0]       rsp_data;

  // master: requesters plus response consumer
  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data
  );

  // slave: the arbiter
  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data
  );
endinterface

// File: rtl/mul8u_share_arb.sv
// Round-robin arbiter + 2-stage sequencer time-sharing one external 8x8 multiplier.
// Latency: grant edge T loads mul_a/mul_b, response valid after T+1 (2 cycles).
// Backpressure: rsp_ready low holds S2; S1 takes one more op, then all req_ready drop.
//
// Ports:
//   clk, rst         single clock, synchronous active-high reset
//   bus (slave)      request channels and tagged response channel
//   mul_a, mul_b     registered operands to the multiplier cell
//   mul_o            combinational product from the multiplier cell
//   op_count         completed response handshakes, wraps modulo 2^32
module mul8u_share_arb #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                clk,
  input  logic                rst,
  mul8u_share_arb_if.slave    bus,
  output logic [7:0]          mul_a,
  output logic [7:0]          mul_b,
  input  logic [15:0]         mul_o,
  output logic [31:0]         op_count
);

  logic [IDW-1:0]    ptr;
  logic              s1_valid;
  logic [IDW-1:0]    s1_id;

  logic              s2_free;
  logic              s1_adv;
  logic              s1_free;
  logic              rsp_fire;
  logic              found;
  logic              grant;
  logic [IDW-1:0]    gnt_idx;
  logic [IDW-1:0]    ptr_nxt;
  logic [IDW:0]      sum;
  logic [IDW:0]      inc;
  logic [2*NREQ-1:0] rv2;
  logic [NREQ-1:0]   rot;
  logic [7:0]        a_sel;
  logic [7:0]        b_sel;

  assign s2_free  = !bus.rsp_valid || bus.rsp_ready;
  assign s1_adv   = s1_valid && s2_free;
  assign s1_free  = !s1_valid || s2_free;
  assign rsp_fire = bus.rsp_valid && bus.rsp_ready;

  // Rotate the request vector so bit 0 is the requester at ptr; the first set
  // bit j then maps back to (ptr + j) mod NREQ.
  assign rv2 = {bus.req_valid, bus.req_valid};

  always_comb begin
    rot     = NREQ'(rv2 >> ptr);
    found   = 1'b0;
    gnt_idx = '0;
    sum     = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (!found && rot[j]) begin
        found = 1'b1;
        sum   = {1'b0, ptr} + (IDW+1)'(j);
        if (sum >= (IDW+1)'(NREQ)) begin
          sum = sum - (IDW+1)'(NREQ);
        end
        gnt_idx = sum[IDW-1:0];
      end
    end
  end

  always_comb begin
    inc     = {1'b0, gnt_idx} + (IDW+1)'(1);
    ptr_nxt = (inc == (IDW+1)'(NREQ)) ? '0 : inc[IDW-1:0];
  end

  // Grant only into a free S1; suppressed while reset is asserted.
  assign grant         = found && s1_free && !rst;
  assign bus.req_ready = grant ? (NREQ'(1) << gnt_idx) : '0;

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (gnt_idx == IDW'(j)) begin
        a_sel = bus.req_a[8*j +: 8];
        b_sel = bus.req_b[8*j +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr          <= '0;
      s1_valid     <= 1'b0;
      s1_id        <= '0;
      mul_a        <= '0;
      mul_b        <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_id    <= '0;
      bus.rsp_data  <= '0;
      op_count     <= '0;
    end else begin
      // Operands only move on a grant so the multiplier sees no toggling when idle.
      if (grant) begin
        ptr      <= ptr_nxt;
        s1_id    <= gnt_idx;
        mul_a    <= a_sel;
        mul_b    <= b_sel;
        s1_valid <= 1'b1;
      end else if (s1_adv) begin
        s1_valid <= 1'b0;
      end

      if (s1_adv) begin
        bus.rsp_valid <= 1'b1;
        bus.rsp_id    <= s1_id;
        bus.rsp_data  <= mul_o;
      end else if (rsp_fire) begin
        bus.rsp_valid <= 1'b0;
      end

      if (rsp_fire) begin
        op_count <= op_count + 32'd1;
      end
    end
  end

endmodule
